// File: rtl/instr_stream_packer_pkg.sv
// Shared constants and state type for the instruction stream packer.
// Defaults mirror the wasm loader defines: 4-byte windows of 8-bit bytes.
package instr_stream_packer_pkg;

    localparam int DEF_WIN     = 4;
    localparam int DEF_LOG_WIN = 2;
    localparam int DEF_BYTE_W  = 8;
    localparam int DEF_CNT_W   = 10;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/instr_stream_packer.sv
// Packs a valid/ready byte stream into instruction memory write windows.
// One write per window; a closed window is held while the memory stalls.
module instr_stream_packer
    import instr_stream_packer_pkg::*;
#(
    parameter int WIN     = DEF_WIN,
    parameter int LOG_WIN = DEF_LOG_WIN,
    parameter int BYTE_W  = DEF_BYTE_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  flush,
    input  logic                  wr_stall,
    output logic                  we,
    output logic [LOG_WIN-1:0]    write_pointer_shift_minusone,
    output logic [WIN*BYTE_W-1:0] wr_data,
    output logic                  load_done,
    output logic [CNT_W:0]        byte_count
);

    localparam int WW = WIN * BYTE_W;

    state_t             r_state;
    state_t             w_state_nx;
    logic [LOG_WIN-1:0] r_fill;
    logic [WW-1:0]      r_slots;
    logic [WW-1:0]      w_win;
    logic [LOG_WIN:0]   w_cnt;
    logic               w_acc;
    logic               w_full;
    logic               w_close;
    logic               w_release;
    logic               w_acc_last;

    logic               r_we;
    logic               r_ld;
    logic               r_hold_last;
    logic [LOG_WIN-1:0] r_shift;
    logic [WW-1:0]      r_data;
    logic [CNT_W:0]     r_bcnt;

    assign s_ready    = !rst && (r_state == FILL);
    assign w_acc      = s_valid && s_ready;
    assign w_acc_last = w_acc && s_last;
    assign w_cnt      = {1'b0, r_fill} + {{LOG_WIN{1'b0}}, w_acc};
    assign w_full     = (r_fill == LOG_WIN'(WIN - 1));

    // A flush that coincides with an accept still closes, byte included.
    assign w_close = (r_state == FILL)
                   && ((w_acc && (w_full || s_last))
                       || (flush && (w_cnt != '0)));

    // The held window goes out in the very cycle the stall drops.
    assign w_release = (r_state == HOLD) && !wr_stall;

    always_comb begin
        w_win = r_slots;
        if (w_acc)
            w_win[r_fill*BYTE_W +: BYTE_W] = s_data;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            FILL: if (w_close && wr_stall) w_state_nx = HOLD;
            HOLD: if (!wr_stall)           w_state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_fill  <= '0;
            r_slots <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_close) begin
                r_fill  <= '0;
                r_slots <= '0;
            end else if (w_acc) begin
                r_fill  <= r_fill + 1'b1;
                r_slots <= w_win;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_ld        <= 1'b0;
            r_hold_last <= 1'b0;
            r_shift     <= '0;
            r_data      <= '0;
            r_bcnt      <= '0;
        end else begin
            r_we <= w_close && !wr_stall;
            r_ld <= w_close && !wr_stall && w_acc_last;
            if (w_close) begin
                r_data      <= w_win;
                r_shift     <= LOG_WIN'(w_cnt - 1'b1);
                r_hold_last <= w_acc_last;
            end
            if (w_close && !wr_stall)
                r_bcnt <= r_bcnt + (CNT_W+1)'(w_cnt);
            else if (w_release)
                r_bcnt <= r_bcnt + (CNT_W+1)'(r_shift) + 1'b1;
        end
    end

    assign we                           = r_we || w_release;
    assign load_done                    = r_ld || (w_release && r_hold_last);
    assign write_pointer_shift_minusone = r_shift;
    assign wr_data                      = r_data;
    assign byte_count                   = r_bcnt;

endmodule

// File: tb/tb_instr_stream_packer.sv
// Directed and randomised checks of the instruction stream packer.
// Inputs driven 2 time units after the rising edge; writes logged on falling edges.
module tb_instr_stream_packer;

    localparam int WIN     = 4;
    localparam int LOG_WIN = 2;
    localparam int BYTE_W  = 8;
    localparam int CNT_W   = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [BYTE_W-1:0]     s_data = '0;
    logic                  s_valid = 1'b0;
    logic                  s_last = 1'b0;
    logic                  s_ready;
    logic                  flush = 1'b0;
    logic                  wr_stall = 1'b0;
    logic                  we;
    logic [LOG_WIN-1:0]    shift;
    logic [WIN*BYTE_W-1:0] wr_data;
    logic                  load_done;
    logic [CNT_W:0]        byte_count;

    instr_stream_packer #(
        .WIN(WIN), .LOG_WIN(LOG_WIN), .BYTE_W(BYTE_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .flush(flush),
        .wr_stall(wr_stall),
        .we(we),
        .write_pointer_shift_minusone(shift),
        .wr_data(wr_data),
        .load_done(load_done),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_rdy_low = 0;
    bit sb_en = 1'b0;
    bit rnd_stall = 1'b0;

    logic [31:0] mq_data[$];
    logic [1:0]  mq_shift[$];
    logic        mq_ld[$];
    int          mq_cyc[$];
    logic [7:0]  sb_q[$];
    bit          sb_last[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            mq_data.push_back(wr_data);
            mq_shift.push_back(shift);
            mq_ld.push_back(load_done);
            mq_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic mq_clear();
        mq_data.delete();
        mq_shift.delete();
        mq_ld.delete();
        mq_cyc.delete();
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        int k = 0;
        s_data  = b;
        s_last  = last;
        s_valid = 1'b1;
        if (rnd_stall) wr_stall = ($urandom_range(0, 3) == 0);
        #1;
        while (!s_ready && k < 100) begin
            step();
            if (rnd_stall) wr_stall = ($urandom_range(0, 3) == 0);
            #1;
            k++;
        end
        if (k >= 100) chk("send_timeout", k, 0);
        n_rdy_low += k;
        step();
        acc_cyc = cyc;
        if (sb_en) begin
            sb_q.push_back(b);
            sb_last.push_back(last);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] t1[8];
        logic [7:0] bv;
        int pos;
        int cnt;
        int err_order;
        int err_zero;
        int err_shape;

        t1 = '{8'h00, 8'h61, 8'h73, 8'h6d, 8'h01, 8'h00, 8'h00, 8'h00};

        // reset state
        step();
        step();
        #1;
        chk("rst_ready", s_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_shift", shift, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_ld", load_done, 0);
        chk("rst_bcnt", byte_count, 0);
        rst = 1'b0;
        step();
        #1;
        chk("post_rst_ready", s_ready, 1);

        // 1: two full windows back to back
        mq_clear();
        n_rdy_low = 0;
        for (int i = 0; i < 8; i++) send(t1[i], 1'b0);
        idle(3);
        chk("t1_nwe", mq_data.size(), 2);
        chk("t1_data0", mq_data[0], 32'h6d736100);
        chk("t1_data1", mq_data[1], 32'h00000001);
        chk("t1_shift0", mq_shift[0], 3);
        chk("t1_shift1", mq_shift[1], 3);
        chk("t1_ld0", mq_ld[0], 0);
        chk("t1_gap", mq_cyc[1] - mq_cyc[0], 4);
        chk("t1_rdy_low", n_rdy_low, 0);
        chk("t1_bcnt", byte_count, 8);

        // 2: short image closed by s_last
        mq_clear();
        send(8'h41, 1'b0);
        send(8'hdd, 1'b0);
        send(8'h01, 1'b1);
        idle(3);
        chk("t2_nwe", mq_data.size(), 1);
        chk("t2_data", mq_data[0], 32'h0001dd41);
        chk("t2_shift", mq_shift[0], 2);
        chk("t2_ld", mq_ld[0], 1);
        chk("t2_latency", mq_cyc[0], acc_cyc);
        chk("t2_bcnt", byte_count, 11);

        // 3: flush of partial window, then flush of empty window
        mq_clear();
        send(8'haa, 1'b0);
        send(8'hbb, 1'b0);
        pulse_flush();
        idle(2);
        chk("t3_nwe", mq_data.size(), 1);
        chk("t3_data", mq_data[0], 32'h0000bbaa);
        chk("t3_shift", mq_shift[0], 1);
        mq_clear();
        pulse_flush();
        idle(2);
        chk("t3_empty_flush", mq_data.size(), 0);
        chk("t3_bcnt", byte_count, 13);

        // 4: memory stall on the closing byte
        mq_clear();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        wr_stall = 1'b1;
        send(8'h44, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_hold_ready", s_ready, 0);
            chk("t4_hold_we", we, 0);
            step();
        end
        wr_stall = 1'b0;
        #1;
        chk("t4_rel_we", we, 1);
        chk("t4_rel_data", wr_data, 32'h44332211);
        chk("t4_rel_shift", shift, 3);
        step();
        #1;
        chk("t4_after_we", we, 0);
        chk("t4_after_ready", s_ready, 1);
        idle(2);
        chk("t4_nwe", mq_data.size(), 1);
        chk("t4_bcnt", byte_count, 17);

        // 5: reset in the middle of a window
        mq_clear();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", s_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("t5_bcnt0", byte_count, 0);
        chk("t5_data0", wr_data, 0);
        send(8'h5a, 1'b0);
        send(8'h6b, 1'b0);
        send(8'h7c, 1'b0);
        send(8'h8d, 1'b0);
        idle(3);
        chk("t5_nwe", mq_data.size(), 1);
        chk("t5_data", mq_data[0], 32'h8d7c6b5a);
        chk("t5_bcnt", byte_count, 4);

        // 6: random gaps and stalls, scoreboard of byte order
        rst = 1'b1;
        step();
        rst = 1'b0;
        mq_clear();
        sb_q.delete();
        sb_last.delete();
        sb_en = 1'b1;
        rnd_stall = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                wr_stall = ($urandom_range(0, 3) == 0);
                step();
            end
            send(8'($urandom_range(0, 255)),
                 (i == 999) || ($urandom_range(0, 49) == 0));
        end
        rnd_stall = 1'b0;
        sb_en = 1'b0;
        wr_stall = 1'b0;
        idle(5);

        pos = 0;
        err_order = 0;
        err_zero = 0;
        err_shape = 0;
        foreach (mq_data[w]) begin
            cnt = int'(mq_shift[w]) + 1;
            for (int k = 0; k < WIN; k++) begin
                bv = mq_data[w][k*8 +: 8];
                if (k < cnt) begin
                    if (pos >= sb_q.size()) begin
                        err_order++;
                    end else begin
                        if (bv !== sb_q[pos]) err_order++;
                        if (k == cnt - 1) begin
                            if (mq_ld[w] !== sb_last[pos]) err_shape++;
                            if (!mq_ld[w] && cnt != WIN) err_shape++;
                        end else if (sb_last[pos]) begin
                            err_shape++;
                        end
                    end
                    pos++;
                end else if (bv !== 8'h00) begin
                    err_zero++;
                end
            end
        end
        chk("t6_order", err_order, 0);
        chk("t6_zero_pad", err_zero, 0);
        chk("t6_shape", err_shape, 0);
        chk("t6_nbytes", pos, 1000);
        chk("t6_bcnt", byte_count, 1000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
